// File: rtl/cpu_pkg.sv
// Shared definitions for the group-1 instruction sequencer: ALU op codes
// (aaa field), addressing-mode codes (bbb field), the sequencer state
// encoding and the one opcode that is excluded from the group.
package cpu_pkg;

  // aaa field of the instruction register
  localparam logic [2:0] OP_ORA = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_EOR = 3'b010;
  localparam logic [2:0] OP_ADC = 3'b011;
  localparam logic [2:0] OP_STA = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_SBC = 3'b111;

  // bbb field of the instruction register
  localparam logic [2:0] MODE_ZPX = 3'b000;
  localparam logic [2:0] MODE_ZP  = 3'b001;
  localparam logic [2:0] MODE_IMM = 3'b010;
  localparam logic [2:0] MODE_ABS = 3'b011;
  localparam logic [2:0] MODE_ZPY = 3'b100;

  // cc field value that identifies a group-1 opcode
  localparam logic [1:0] CC_GROUP1 = 2'b01;

  // STA #imm has no meaning (nothing to store into) and is rejected
  localparam logic [7:0] OPC_STA_IMM = 8'h89;

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_FETCH    = 3'd1,
    ST_OPND     = 3'd2,
    ST_ADH      = 3'd3,
    ST_INDEX    = 3'd4,
    ST_EXEC     = 3'd5,
    ST_HALT     = 3'd6
  } state_t;

endpackage : cpu_pkg

// File: rtl/group1_decode.sv
// Purely combinational opcode decode: splits an opcode into its fields and
// reports the addressing mode, whether the opcode is supported, whether it
// is a store, and which index register an indexed mode uses.
module group1_decode
  import cpu_pkg::*;
(
  input  logic [7:0] i_ir,
  output logic [2:0] o_mode,
  output logic       o_legal,
  output logic       o_is_sta,
  output logic       o_use_y
);

  logic [2:0] w_aaa;
  logic [2:0] w_bbb;
  logic [1:0] w_cc;

  assign w_aaa = i_ir[7:5];
  assign w_bbb = i_ir[4:2];
  assign w_cc  = i_ir[1:0];

  assign o_mode   = w_bbb;
  assign o_legal  = (w_cc == CC_GROUP1) && (w_bbb <= MODE_ZPY) &&
                    (i_ir != OPC_STA_IMM);
  assign o_is_sta = (w_aaa == OP_STA);
  assign o_use_y  = (w_bbb == MODE_ZPY);

endmodule : group1_decode

// File: rtl/group1_seq.sv
// Group-1 instruction sequencer: walks each opcode through fetch, operand,
// optional high-address and index cycles, then the execute cycle, driving
// the bus address and the PC / ALU / memory-write strobes. Unsupported
// opcodes park the sequencer in HALT until reset.
module group1_seq
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  d_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  output logic [15:0] addr,
  output logic        pc_inc,
  output logic [2:0]  alu_op,
  output logic        alu_go,
  output logic        mem_we,
  output logic        sync,
  output logic        illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ir;
  logic [7:0] r_adl;
  logic [7:0] r_adh;
  logic       r_illegal;

  logic [7:0] w_dec_in;
  logic [2:0] w_mode;
  logic       w_legal;
  logic       w_is_sta;
  logic       w_use_y;
  logic       w_pc_inc;
  logic       w_alu_go;
  logic       w_mem_we;

  // In FETCH the opcode is still on the bus, so legality must be judged
  // from d_in before it lands in IR; every later state decodes IR.
  assign w_dec_in = (r_state == ST_FETCH) ? d_in : r_ir;

  group1_decode u_decode (
    .i_ir     (w_dec_in),
    .o_mode   (w_mode),
    .o_legal  (w_legal),
    .o_is_sta (w_is_sta),
    .o_use_y  (w_use_y)
  );

  // Next-state, address mux and raw (un-stalled) strobes for the current state
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    w_next   = r_state;
    addr     = pc_in;
    sync     = 1'b0;
    w_pc_inc = 1'b0;
    w_alu_go = 1'b0;
    w_mem_we = 1'b0;
    unique case (r_state)
      ST_RST_WAIT: w_next = ST_FETCH;
      ST_FETCH: begin
        sync     = 1'b1;
        w_pc_inc = 1'b1;
        w_next   = w_legal ? ST_OPND : ST_HALT;
      end
      ST_OPND: begin
        w_pc_inc = 1'b1;
        case (w_mode)
          MODE_IMM: begin
            w_alu_go = 1'b1;
            w_next   = ST_FETCH;
          end
          MODE_ZP:  w_next = ST_EXEC;
          MODE_ABS: w_next = ST_ADH;
          default:  w_next = ST_INDEX;
        endcase
      end
      ST_ADH: begin
        w_pc_inc = 1'b1;
        w_next   = ST_EXEC;
      end
      ST_INDEX: begin
        addr   = {8'h00, r_adl};
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        addr     = (w_mode == MODE_ABS) ? {r_adh, r_adl} : {8'h00, r_adl};
        w_mem_we = w_is_sta;
        w_alu_go = !w_is_sta;
        w_next   = ST_FETCH;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST_WAIT;
    endcase
  end

  // A stalled bus cycle does nothing, so every side-effecting strobe is gated
  assign pc_inc  = w_pc_inc & rdy;
  assign alu_go  = w_alu_go & rdy;
  assign mem_we  = w_mem_we & rdy;
  assign alu_op  = r_ir[7:5];
  assign illegal = r_illegal;

  // State register: advances only on ready cycles
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_state <= ST_RST_WAIT;
    end else if (rdy) begin
      r_state <= w_next;
    end
  end

  // Instruction and effective-address registers, loaded per state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir  <= 8'h00;
      r_adl <= 8'h00;
      r_adh <= 8'h00;
    end else if (rdy) begin
      case (r_state)
        ST_FETCH: r_ir  <= d_in;
        ST_OPND:  r_adl <= d_in;
        ST_ADH:   r_adh <= d_in;
        // zero-page indexing wraps within page zero: 8-bit sum, carry dropped
        ST_INDEX: r_adl <= r_adl + (w_use_y ? y_in : x_in);
        default:  ;
      endcase
    end
  end

  // Sticky unsupported-opcode flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (rdy && (r_state == ST_FETCH) && !w_legal) begin
      r_illegal <= 1'b1;
    end
  end

endmodule : group1_seq

// File: tb/tb_group1_seq.sv
// Self-checking bench for group1_seq. A 64 KiB memory model answers bus
// reads and a PC model follows pc_inc. Each instruction is predicted at the
// instruction level (length in bytes and cycles, effective address, which
// strobe fires, operand value) and compared with what the bus shows.
module tb_group1_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [7:0]  d_in;
  logic [15:0] pc_in;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic [15:0] addr;
  logic        pc_inc;
  logic [2:0]  alu_op;
  logic        alu_go;
  logic        mem_we;
  logic        sync;
  logic        illegal;

  logic [7:0] mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  // values sampled at the falling edge of the most recent step
  logic [15:0] s_addr;
  logic        s_pc_inc, s_alu_go, s_mem_we, s_sync, s_illegal;
  logic [2:0]  s_alu_op;
  logic [7:0]  s_din;
  logic        bad_quiet;

  assign d_in = mem[addr];

  always #5 clk = ~clk;

  group1_seq dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .d_in    (d_in),
    .pc_in   (pc_in),
    .x_in    (x_in),
    .y_in    (y_in),
    .addr    (addr),
    .pc_inc  (pc_inc),
    .alu_op  (alu_op),
    .alu_go  (alu_go),
    .mem_we  (mem_we),
    .sync    (sync),
    .illegal (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic legal_opc(input logic [7:0] o);
    return (o[1:0] == 2'b01) && (o[4:2] <= 3'd4) && (o != 8'h89);
  endfunction

  // One bus cycle: set rdy, sample outputs mid-cycle, then let the PC model
  // react just after the rising edge.
  task automatic step(input logic r);
    rdy = r;
    @(negedge clk);
    s_addr    = addr;
    s_pc_inc  = pc_inc;
    s_alu_go  = alu_go;
    s_mem_we  = mem_we;
    s_sync    = sync;
    s_illegal = illegal;
    s_alu_op  = alu_op;
    s_din     = d_in;
    if (!r && (pc_inc || alu_go || mem_we)) bad_quiet = 1'b1;
    if (alu_go && mem_we) bad_quiet = 1'b1;
    @(posedge clk);
    #1;
    if (s_pc_inc) pc_in = pc_in + 16'd1;
  endtask

  // Assert reset for one cycle (checking reset outputs), release it, and
  // step through RST_WAIT so the next cycle is the first FETCH.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    step(1'b1);
    check({tag, "_rst_sync"}, 32'(s_sync), 32'd0);
    check({tag, "_rst_strobes"}, 32'({s_pc_inc, s_alu_go, s_mem_we}), 32'd0);
    check({tag, "_rst_illegal"}, 32'(s_illegal), 32'd0);
    check({tag, "_rst_addr"}, 32'(s_addr), 32'(pc_in));
    check({tag, "_rst_aluop"}, 32'(s_alu_op), 32'd0);
    rst = 1'b0;
    step(1'b1);
    check({tag, "_rstwait_quiet"}, 32'({s_sync, s_pc_inc, s_alu_go, s_mem_we}), 32'd0);
  endtask

  // Run one supported instruction from its FETCH cycle to just before the
  // next FETCH. stall_len ready-low cycles are inserted in front of active
  // cycle number stall_at (0-based); rand_stall adds random stalls.
  task automatic run_instr(input string tag, input logic [7:0] opc, input logic [7:0] lo,
                           input logic [7:0] hi, input int stall_at, input int stall_len,
                           input logic rand_stall);
    logic [15:0] base, ea, first_addr, idx_addr, ev_addr, pend_addr;
    logic [2:0]  aaa, bbb;
    logic [7:0]  sum, exp_opnd, ev_din;
    logic [2:0]  ev_op;
    logic        is_sta, first_sync, sync_bad, hold_bad, pend, r;
    int          n_bytes, n_cyc, active, guard, stalled, n_inc, n_alu, n_we;
    base = pc_in;
    mem[base] = opc;
    mem[base + 16'd1] = lo;
    mem[base + 16'd2] = hi;
    aaa = opc[7:5];
    bbb = opc[4:2];
    is_sta = (aaa == 3'b100);
    case (bbb)
      3'd0:    begin sum = lo + x_in; ea = {8'h00, sum}; n_bytes = 2; n_cyc = 4; end
      3'd1:    begin ea = {8'h00, lo};  n_bytes = 2; n_cyc = 3; end
      3'd2:    begin ea = base + 16'd1; n_bytes = 2; n_cyc = 2; end
      3'd3:    begin ea = {hi, lo};     n_bytes = 3; n_cyc = 4; end
      default: begin sum = lo + y_in; ea = {8'h00, sum}; n_bytes = 2; n_cyc = 4; end
    endcase
    exp_opnd = mem[ea];
    bad_quiet = 1'b0;
    active = 0; guard = 0; stalled = 0; n_inc = 0; n_alu = 0; n_we = 0;
    first_sync = 1'b0; sync_bad = 1'b0; hold_bad = 1'b0; pend = 1'b0;
    first_addr = '0; idx_addr = '0; ev_addr = '0; pend_addr = '0; ev_op = '0; ev_din = '0;
    while (active < n_cyc && guard < 64) begin
      r = 1'b1;
      if (active == stall_at && stalled < stall_len) begin
        r = 1'b0;
        stalled++;
      end else if (rand_stall && $urandom_range(0, 3) == 0) begin
        r = 1'b0;
      end
      step(r);
      guard++;
      if (r) begin
        active++;
        if (pend && s_addr != pend_addr) hold_bad = 1'b1;
        pend = 1'b0;
        if (active == 1) begin
          first_sync = s_sync;
          first_addr = s_addr;
        end else if (s_sync) begin
          sync_bad = 1'b1;
        end
        if (active == 3) idx_addr = s_addr;
        n_inc += int'(s_pc_inc);
        if (s_alu_go) begin
          n_alu++; ev_addr = s_addr; ev_op = s_alu_op; ev_din = s_din;
        end
        if (s_mem_we) begin
          n_we++; ev_addr = s_addr; ev_op = s_alu_op;
        end
      end else begin
        if (pend && s_addr != pend_addr) hold_bad = 1'b1;
        pend = 1'b1;
        pend_addr = s_addr;
      end
    end
    check({tag, "_budget"}, 32'(active), 32'(n_cyc));
    check({tag, "_sync_first"}, 32'(first_sync), 32'd1);
    check({tag, "_fetch_addr"}, 32'(first_addr), 32'(base));
    check({tag, "_sync_once"}, 32'(sync_bad), 32'd0);
    check({tag, "_pc_incs"}, 32'(n_inc), 32'(n_bytes));
    check({tag, "_n_alu_go"}, 32'(n_alu), is_sta ? 32'd0 : 32'd1);
    check({tag, "_n_mem_we"}, 32'(n_we), is_sta ? 32'd1 : 32'd0);
    check({tag, "_ev_addr"}, 32'(ev_addr), 32'(ea));
    check({tag, "_ev_op"}, 32'(ev_op), 32'(aaa));
    if (!is_sta) check({tag, "_operand"}, 32'(ev_din), 32'(exp_opnd));
    if (bbb == 3'd0 || bbb == 3'd4) check({tag, "_index_addr"}, 32'(idx_addr), 32'({8'h00, lo}));
    check({tag, "_stall_hold"}, 32'(hold_bad), 32'd0);
    check({tag, "_quiet"}, 32'(bad_quiet), 32'd0);
    check({tag, "_pc_end"}, 32'(pc_in), 32'(base + 16'(n_bytes)));
  endtask

  // Fetch an unsupported opcode, watch the HALT state, then reset out of it.
  task automatic run_illegal(input string tag, input logic [7:0] opc);
    logic [15:0] base;
    logic        bad;
    base = pc_in;
    mem[base] = opc;
    bad_quiet = 1'b0;
    bad = 1'b0;
    step(1'b1);
    check({tag, "_fetch"}, 32'({s_sync, s_pc_inc}), 32'h3);
    for (int i = 0; i < 5; i++) begin
      step($urandom_range(0, 1) == 1);
      if (s_pc_inc || s_alu_go || s_mem_we || s_sync || !s_illegal || s_addr != pc_in)
        bad = 1'b1;
    end
    check({tag, "_halt"}, 32'(bad), 32'd0);
    check({tag, "_halt_pc"}, 32'(pc_in), 32'(base + 16'd1));
    check({tag, "_quiet"}, 32'(bad_quiet), 32'd0);
    apply_reset({tag, "_clr"});
  endtask

  initial begin
    logic [7:0]  opc;
    logic [2:0]  aaa, bbb;
    logic [15:0] base;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    pc_in = 16'h8000;
    x_in  = 8'h00;
    y_in  = 8'h00;
    rst   = 1'b1;
    rdy   = 1'b1;
    apply_reset("por");

    // LDA #$42
    run_instr("lda_imm", 8'hA9, 8'h42, 8'h00, -1, 0, 1'b0);
    // ADC $1234
    run_instr("adc_abs", 8'h6D, 8'h34, 8'h12, -1, 0, 1'b0);
    // STA $F0,X: with ZPX=000 the opcode is 100_000_01 = 0x81; 0xF0+0x20 wraps to 0x10
    x_in = 8'h20;
    run_instr("sta_zpx", 8'h81, 8'hF0, 8'h00, -1, 0, 1'b0);
    // LDA $ABCD with three stalled cycles while in ADH
    run_instr("lda_abs_stall", 8'hAD, 8'hCD, 8'hAB, 2, 3, 1'b0);
    run_instr("after_stall", 8'h25, 8'h10, 8'h00, -1, 0, 1'b0);

    // unsupported opcodes
    run_illegal("ill_89", 8'h89);
    run_illegal("ill_0a", 8'h0A);

    // reset during the INDEX cycle of ORA $40,Y
    y_in = 8'h05;
    base = pc_in;
    mem[base] = 8'h11;
    mem[base + 16'd1] = 8'h40;
    step(1'b1);
    step(1'b1);
    apply_reset("rst_index");
    run_instr("post_rst", 8'hC5, 8'h33, 8'h00, -1, 0, 1'b0);

    // randomized instruction stream with random stalls and index values
    for (int n = 0; n < 120; n++) begin
      aaa = 3'($urandom_range(0, 7));
      bbb = 3'($urandom_range(0, 4));
      if (aaa == 3'b100 && bbb == 3'b010) bbb = 3'b001;
      x_in = 8'($urandom);
      y_in = 8'($urandom);
      run_instr("rnd", {aaa, bbb, 2'b01}, 8'($urandom), 8'($urandom), -1, 0, 1'b1);
    end

    // a few random unsupported opcodes
    for (int n = 0; n < 4; n++) begin
      do opc = 8'($urandom); while (legal_opc(opc));
      run_illegal("rnd_ill", opc);
      run_instr("rnd_ill_next", 8'h45, 8'h77, 8'h00, -1, 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_group1_seq
